// File: rtl/register_file_32x32.sv
// MIPS general-purpose register file: 2**ADDR_WIDTH x DATA_WIDTH, two async read
// ports, one sync write port, $0 hardwired to zero, optional write-through bypass.

module register_file_32x32_entry #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);

  // Reset outranks the write enable so a write in the reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (!reset)  q <= '0;
    else if (we) q <= wdata;
  end

endmodule

module register_file_32x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit BYPASS     = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_reg_1,
  input  logic [ADDR_WIDTH-1:0] read_reg_2,
  input  logic [ADDR_WIDTH-1:0] write_reg,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reg_write,
  output logic [DATA_WIDTH-1:0] read_data_1,
  output logic [DATA_WIDTH-1:0] read_data_2
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 we_vec;
  logic                             wr_live;
  logic                             hit_1, hit_2;

  assign wr_live = reg_write && (write_reg != '0);

  // Entry 0 has no storage; it is a constant so the read mux never sees X.
  assign regs[0]   = '0;
  assign we_vec[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_ent
      assign we_vec[gi] = wr_live && (write_reg == ADDR_WIDTH'(gi));

      register_file_32x32_entry #(
        .DATA_WIDTH (DATA_WIDTH)
      ) u_ent (
        .clock (clock),
        .reset (reset),
        .we    (we_vec[gi]),
        .wdata (write_data),
        .q     (regs[gi])
      );
    end
  endgenerate

  // Write-through only for a live write outside reset; wr_live already excludes $0.
  assign hit_1 = BYPASS && reset && wr_live && (read_reg_1 == write_reg);
  assign hit_2 = BYPASS && reset && wr_live && (read_reg_2 == write_reg);

  always_comb begin
    read_data_1 = regs[read_reg_1];
    if (read_reg_1 == '0) read_data_1 = '0;
    else if (hit_1)       read_data_1 = write_data;
  end

  always_comb begin
    read_data_2 = regs[read_reg_2];
    if (read_reg_2 == '0) read_data_2 = '0;
    else if (hit_2)       read_data_2 = write_data;
  end

endmodule

// File: tb/tb_register_file_32x32.sv
// Directed bench: one build without bypass (a) and one with write-through (b),
// both driven by the same stimulus.

module tb_register_file_32x32;

  logic        clock;
  logic        reset;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;

  int total = 0;
  int bad   = 0;

  register_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b0)) dut_a (
    .clock (clock), .reset (reset),
    .read_reg_1 (read_reg_1), .read_reg_2 (read_reg_2),
    .write_reg (write_reg), .write_data (write_data), .reg_write (reg_write),
    .read_data_1 (rd1_a), .read_data_2 (rd2_a)
  );

  register_file_32x32 #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1'b1)) dut_b (
    .clock (clock), .reset (reset),
    .read_reg_1 (read_reg_1), .read_reg_2 (read_reg_2),
    .write_reg (write_reg), .write_data (write_data), .reg_write (reg_write),
    .read_data_1 (rd1_b), .read_data_2 (rd2_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [31:0] e1, input logic [31:0] e2);
    check({name, " a.rd1"}, rd1_a, e1);
    check({name, " a.rd2"}, rd2_a, e2);
    check({name, " b.rd1"}, rd1_b, e1);
    check({name, " b.rd2"}, rd2_b, e2);
  endtask

  // Apply write-side inputs across one rising edge, then go idle and settle.
  task automatic edge_idle();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    reg_write = 1'b0;
    #1;
  endtask

  initial begin
    // rst, we, wr, wd, r1, r2, e1, e2
    vecs[0] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd0,  5'd31, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 5'd6, 32'hCAFEF00D, 5'd5,  5'd6,  32'h0,        32'h0};
    vecs[3] = '{1'b1, 1'b1, 5'd8, 32'h12345678, 5'd8,  5'd8,  32'h12345678, 32'h12345678};
    vecs[4] = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0,  5'd1,  32'h0,        32'h0};
    vecs[5] = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd31, 5'd8,  32'h0,        32'h12345678};
    vecs[6] = '{1'b1, 1'b1, 5'd9, 32'h0000000A, 5'd9,  5'd0,  32'h0000000A, 32'h0};
    vecs[7] = '{1'b1, 1'b0, 5'd9, 32'h0000000B, 5'd9,  5'd8,  32'h0000000A, 32'h12345678};
    vecs[8] = '{1'b1, 1'b1, 5'd3, 32'h11111111, 5'd3,  5'd9,  32'h11111111, 32'h0000000A};

    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg_1 = '0; read_reg_2 = '0;
    #2;
    check4("pre-reset $0", 32'h0, 32'h0);

    for (int i = 0; i < 9; i++) begin
      reset      = vecs[i].rst;
      reg_write  = vecs[i].we;
      write_reg  = vecs[i].wr;
      write_data = vecs[i].wd;
      read_reg_1 = vecs[i].r1;
      read_reg_2 = vecs[i].r2;
      edge_idle();
      check4($sformatf("vec%0d", i), vecs[i].e1, vecs[i].e2);
    end

    // Collision on $3: old value without bypass, new value with bypass.
    read_reg_1 = 5'd9; read_reg_2 = 5'd3;
    write_reg = 5'd3; write_data = 32'h22222222; reg_write = 1'b1;
    #1;
    check("coll pre a.rd2", rd2_a, 32'h11111111);
    check("coll pre b.rd2", rd2_b, 32'h22222222);
    check("coll pre b.rd1", rd1_b, 32'h0000000A);
    // Bypass is suppressed while reset is low.
    reset = 1'b0; #1;
    check("coll rst b.rd2", rd2_b, 32'h11111111);
    reset = 1'b1; #1;
    edge_idle();
    check4("coll post", 32'h0000000A, 32'h22222222);

    // Write to $0 with both ports on $0: bypass must not apply.
    read_reg_1 = 5'd0; read_reg_2 = 5'd0;
    write_reg = 5'd0; write_data = 32'h5A5A5A5A; reg_write = 1'b1;
    #1;
    check("byp $0 b.rd1", rd1_b, 32'h0);
    check("byp $0 b.rd2", rd2_b, 32'h0);
    edge_idle();

    // Reset low between edges only: no effect.
    @(negedge clock);
    read_reg_1 = 5'd3; read_reg_2 = 5'd5;
    reset = 1'b0; #2; reset = 1'b1;
    edge_idle();
    check4("glitch rst", 32'h22222222, 32'h0);

    // Full sweep on consecutive edges.
    for (int i = 1; i < 32; i++) begin
      reg_write = 1'b1; write_reg = 5'(i); write_data = i * 32'h01010101;
      @(posedge clock); #1;
    end
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      logic [31:0] e1, e2;
      read_reg_1 = 5'(i); read_reg_2 = 5'(31 - i);
      e1 = i * 32'h01010101;
      e2 = (31 - i) * 32'h01010101;
      #1;
      check4($sformatf("sweep%0d", i), e1, e2);
    end

    // Reset after sweep clears everything.
    reset = 1'b0;
    edge_idle();
    read_reg_1 = 5'd17; read_reg_2 = 5'd31; #1;
    check4("final rst", 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_32x32.md
Name: register_file_32x32

Overview:
- MIPS general-purpose register file.
- Sits directly downstream of the 5-bit destination-register select mux; that mux's output drives write_reg here.
- Two asynchronous read ports feed the ALU operand path; one synchronous write port is driven by the writeback path.
- Register $0 is hardwired to zero.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH (32)
BYPASS, 0, 1 = a read of the address being written this cycle returns write_data (write-through); 0 = the read returns stored contents

Ports:
clock  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clock
read_reg_1  input  ADDR_WIDTH  read address, port 1 (rs field)
read_reg_2  input  ADDR_WIDTH  read address, port 2 (rt field)
write_reg  input  ADDR_WIDTH  write address, from destination-register select mux (rt/rd)
write_data  input  DATA_WIDTH  writeback data
reg_write  input  1  write enable, active-high
read_data_1  output  DATA_WIDTH  contents of register read_reg_1
read_data_2  output  DATA_WIDTH  contents of register read_reg_2

Behaviour:
- Storage: 2**ADDR_WIDTH registers of DATA_WIDTH bits. Entry 0 is never written and always reads 0.
- Reset:
  - Synchronous and active-low; only sampled on the rising edge of clock.
  - At a rising edge with reset=0, all registers clear to 0.
  - A write presented in the same cycle is discarded; reset has priority over reg_write.
  - reset=0 between edges has no effect until the next rising edge.
  - After the reset edge, read_data_1 and read_data_2 are 0 for every address until a write occurs.
  - Before the first reset edge, contents are undefined, except register 0, which reads 0.
- Write:
  - Occurs at a rising edge with reset=1, reg_write=1 and write_reg!=0: reg[write_reg] <= write_data.
  - reg_write=0, or write_reg=0, leaves every register unchanged.
  - Write latency is 1 cycle: the new value is visible on the read ports immediately after the edge.
- Read:
  - Purely combinational, with zero latency: read_data_n = (read_reg_n==0) ? 0 : reg[read_reg_n].
  - Both ports may address the same register simultaneously; both return the same value.
- Same-cycle read/write collision (read_reg_n==write_reg, reg_write=1, write_reg!=0, reset=1):
  - BYPASS=0: read_data_n shows the old value until the edge, then the new value.
  - BYPASS=1: read_data_n shows write_data combinationally in that cycle.
  - The bypass never applies to address 0 or while reset=0.
- No X-propagation from unused state: every read mux input is a defined register or constant 0.
- Write addresses can never be out of range; ADDR_WIDTH fully covers the depth.

Test Plan:
- Reset clear: write 0xDEADBEEF to $5, then reset=0 for one edge -> read_reg_1=5 gives read_data_1=0x00000000; with reg_write=1 to $6 during the reset edge, $6 reads 0.
- Basic write/read: reg_write=1, write_reg=8, write_data=0x12345678, one edge; then read_reg_1=8, read_reg_2=8 -> both outputs 0x12345678 in the same cycle.
- $0 immutability: reg_write=1, write_reg=0, write_data=0xFFFFFFFF, one edge -> read_reg_1=0 gives 0x00000000; no other register changes (spot-check $1 and $31 remain 0).
- Write enable gating: $9 holds 0x0000000A; reg_write=0, write_reg=9, write_data=0x0000000B, one edge -> $9 still reads 0x0000000A.
- Collision: $3=0x11111111; read_reg_2=3, write_reg=3, write_data=0x22222222, reg_write=1 -> before the edge read_data_2 is 0x11111111 (BYPASS=0) or 0x22222222 (BYPASS=1); after the edge it is 0x22222222 in both builds.
- Full sweep: write reg[i]=i*0x01010101 for i=1..31 on consecutive edges, then read all pairs (i, 31-i) -> exact values on both ports; address 0 reads 0.
